// File: rtl/first_counter_pkg.sv
// Shared constants and slice-geometry helpers for the sliced free-running counter.
package first_counter_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_SLICE_WIDTH = 8;

  function automatic int nslices(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

  // The top slice is clipped to the counter width, so it may be narrower.
  function automatic int slice_msb(input int i, input int w, input int s);
    return ((i + 1) * s > w) ? w - 1 : (i + 1) * s - 1;
  endfunction

endpackage

// File: rtl/first_counter_if.sv
// Debug/LED tap bundle carrying the counter value from its driver to observers.
interface first_counter_if #(
  parameter int WIDTH = first_counter_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] count;

  modport master (output count);
  modport slave  (input  count);
endinterface

// File: rtl/counter_slice.sv
// One slice of the counter: adds its step bits plus the incoming carry every clock.
module counter_slice #(
  parameter int           W         = 8,
  parameter logic [W-1:0] STEP_BITS = '0,
  parameter logic [W-1:0] RST_BITS  = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carry_in,
  input  logic         add_bits,
  output logic [W-1:0] q,
  output logic         carry_out
);

  logic [W-1:0] q_q, q_d;
  logic [W:0]   sum;

  // With add_bits low the lowest carry_in is also low, so every slice holds.
  assign sum       = {1'b0, q_q} + {1'b0, (add_bits ? STEP_BITS : {W{1'b0}})}
                   + {{W{1'b0}}, carry_in};
  assign q_d       = sum[W-1:0];
  assign carry_out = sum[W];
  assign q         = q_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q_q <= RST_BITS;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/first_counter.sv
// Free-running WIDTH-bit up-counter built from sliced adders with a combinational carry chain.
module first_counter
  import first_counter_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter logic [63:0] STEP        = 64'd1,
  parameter logic [63:0] RESET_VALUE = 64'd0,
  parameter int          SLICE_WIDTH = DEF_SLICE_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] count_out
);

  localparam int               NS     = nslices(WIDTH, SLICE_WIDTH);
  localparam logic [WIDTH-1:0] STEP_V = STEP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_V  = RESET_VALUE[WIDTH-1:0];

  logic s1_q, s2_q, run;
  logic [NS-1:0] cin, cout;
  logic unused_wrap;

  // Assertion is immediate; release only takes effect two edges later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= 1'b1;
      s2_q <= s1_q;
    end
  end

  assign run         = s2_q;
  assign unused_wrap = cout[NS-1];

  for (genvar i = 0; i < NS; i++) begin : g_slice
    localparam int LSB = i * SLICE_WIDTH;
    localparam int MSB = slice_msb(i, WIDTH, SLICE_WIDTH);

    if (i == 0) begin : g_c0
      assign cin[i] = 1'b0;
    end else begin : g_cn
      assign cin[i] = cout[i-1];
    end

    counter_slice #(
      .W         (MSB - LSB + 1),
      .STEP_BITS (STEP_V[MSB:LSB]),
      .RST_BITS  (RST_V[MSB:LSB])
    ) u_slice (
      .clock     (clock),
      .reset     (reset),
      .carry_in  (cin[i]),
      .add_bits  (run),
      .q         (count_out[MSB:LSB]),
      .carry_out (cout[i])
    );
  end

endmodule

// File: tb/tb_first_counter.sv
// Scoreboard bench: stimulus queues expected counts, a monitor compares after each edge or reset drop.
module tb_first_counter;

  logic clock;
  logic reset;

  logic [31:0] c1, c2, c3, c4;
  logic [7:0]  c5;

  first_counter_if #(.WIDTH(32)) cif ();

  first_counter #(.WIDTH(32), .STEP(64'd1), .RESET_VALUE(64'd0), .SLICE_WIDTH(8))
    dut0 (.clock(clock), .reset(reset), .count_out(cif.count));
  first_counter #(.WIDTH(32), .STEP(64'd1), .RESET_VALUE(64'hFFFF_FFFD), .SLICE_WIDTH(8))
    dut1 (.clock(clock), .reset(reset), .count_out(c1));
  first_counter #(.WIDTH(32), .STEP(64'd1), .RESET_VALUE(64'h0000_00FF), .SLICE_WIDTH(8))
    dut2 (.clock(clock), .reset(reset), .count_out(c2));
  first_counter #(.WIDTH(32), .STEP(64'd1), .RESET_VALUE(64'h0000_FFFF), .SLICE_WIDTH(8))
    dut3 (.clock(clock), .reset(reset), .count_out(c3));
  first_counter #(.WIDTH(32), .STEP(64'd1), .RESET_VALUE(64'h00FF_FFFF), .SLICE_WIDTH(8))
    dut4 (.clock(clock), .reset(reset), .count_out(c4));
  first_counter #(.WIDTH(8), .STEP(64'd3), .RESET_VALUE(64'hFE), .SLICE_WIDTH(3))
    dut5 (.clock(clock), .reset(reset), .count_out(c5));

  typedef struct {
    int          id;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] actual(input int id);
    case (id)
      0:       return {32'b0, cif.count};
      1:       return {32'b0, c1};
      2:       return {32'b0, c2};
      3:       return {32'b0, c3};
      4:       return {32'b0, c4};
      default: return {56'b0, c5};
    endcase
  endfunction

  task automatic push(input int id, input logic [63:0] val, input string name);
    exp_t e;
    e.id = id; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_all_reset(input string name);
    push(0, 64'h0, name);
    push(1, 64'hFFFF_FFFD, name);
    push(2, 64'h0000_00FF, name);
    push(3, 64'h0000_FFFF, name);
    push(4, 64'h00FF_FFFF, name);
    push(5, 64'hFE, name);
  endtask

  // Monitor: samples 1 ns after every rising edge and every reset assertion.
  initial begin
    exp_t e;
    logic [63:0] a;
    forever begin
      @(posedge clock or negedge reset);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.id);
        n_checks++;
        if (a !== e.val) begin
          n_fail++;
          $display("FAIL %s dut%0d: got %h expected %h at %0t", e.name, e.id, a, e.val, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); push_all_reset("rst_hold");
    end

    // First release: two edges of synchroniser latency, then counting.
    @(negedge clock); reset = 1'b1; push_all_reset("rel_e1");
    @(negedge clock); push_all_reset("rel_e2");
    @(negedge clock);
    push(0, 64'h1, "rel_e3");
    push(1, 64'hFFFF_FFFE, "wrap_a");
    push(2, 64'h0000_0100, "carry_s0");
    push(3, 64'h0001_0000, "carry_s1");
    push(4, 64'h0100_0000, "carry_s2");
    push(5, 64'h01, "step3_a");
    @(negedge clock);
    push(0, 64'h2, "rel_e4");
    push(1, 64'hFFFF_FFFF, "wrap_b");
    push(5, 64'h04, "step3_b");
    @(negedge clock);
    push(0, 64'h3, "run");
    push(1, 64'h0000_0000, "wrap_c");
    push(5, 64'h07, "step3_c");
    @(negedge clock);
    push(0, 64'h4, "run");
    push(1, 64'h0000_0001, "wrap_d");
    for (int k = 7; k <= 39; k++) begin
      @(negedge clock); push(0, 64'(k - 2), (k == 39) ? "at_25" : "run");
    end

    // Mid-phase reset drop at count 0x25: clears with no clock edge.
    @(negedge clock);
    push(0, 64'h0, "async_clr");
    push(5, 64'hFE, "async_clr");
    reset = 1'b0;
    @(negedge clock); push_all_reset("rst_hold2");
    @(negedge clock); reset = 1'b1; push(0, 64'h0, "rel2_e1");
    @(negedge clock); push(0, 64'h0, "rel2_e2");
    for (int k = 3; k <= 100; k++) begin
      @(negedge clock); push(0, 64'(k - 2), (k == 100) ? "run100" : "run2");
    end

    // Sub-cycle reset glitch still clears count and synchroniser.
    @(negedge clock);
    push(0, 64'h0, "glitch");
    reset = 1'b0;
    #2;
    reset = 1'b1;
    push(0, 64'h0, "gl_e1");
    @(negedge clock); push(0, 64'h0, "gl_e2");
    @(negedge clock); push(0, 64'h1, "gl_e3");

    @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
